game_tick_scheduler: RTL

//  Shares one base prescaler among NUM_CH game subsystems (alien march, player shot, alien shot, UFO).

---
 rtl/game_tick_pkg.sv | 14 +
 rtl/game_tick_channel.sv | 59 +++++
 rtl/game_tick_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/game_tick_pkg.sv
// Shared encodings and default widths for the game tick scheduler.
package game_tick_pkg;

  localparam int unsigned STATE_W        = 2;
  localparam int unsigned DEF_PRESCALE_W = 16;
  localparam int unsigned DEF_PERIOD_W   = 10;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_e;

endpackage

// File: rtl/game_tick_channel.sv
// One tick channel: programmable period, base-tick counter and registered tick output.
module game_tick_channel
  import game_tick_pkg::*;
#(
  parameter int unsigned PERIOD_W   = DEF_PERIOD_W,
  parameter int unsigned DEF_PERIOD = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                base_tick,
  input  logic                period_we,
  input  logic [PERIOD_W-1:0] period_new,
  input  logic                cnt_clr,
  output logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q <= PERIOD_W'(DEF_PERIOD);
      cnt_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    if (period_we) begin
      period_d = period_new;
    end
    // A clear (config write or idle) overrides a coincident base tick.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (base_tick) begin
      if (period_q == '0) begin
        cnt_d = '0;
      end else if (cnt_q >= period_q - 1'b1) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign period = period_q;
  assign tick   = tick_q;

endmodule

// File: rtl/game_tick_scheduler.sv
// Shared prescaler, run/pause/stop FSM and per-channel tick generation.
// Optional SINGLE_STEP_EN: a step pulse in PAUSED issues one base tick.
module game_tick_scheduler
  import game_tick_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W,
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PERIOD_W   = DEF_PERIOD_W,
  parameter int unsigned DEF_PERIOD = 8,
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      stop,
  input  logic                      step,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [PERIOD_W-1:0]       cfg_period,
  input  logic                      speed_up,
  output logic                      base_tick,
  output logic [NUM_CH-1:0]         tick,
  output logic [STATE_W-1:0]        state
);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  wrap;
  logic                  step_tick;
  logic                  speed_dec;
  logic [PERIOD_W-1:0]   period [NUM_CH];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // Next state: stop > pause > start
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (pause && state_q == ST_RUN) begin
      state_d = ST_PAUSED;
    end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSED)) begin
      state_d = ST_RUN;
    end else if (state_q != ST_RUN && state_q != ST_PAUSED) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    presc_d = '0;
    case (state_q)
      ST_RUN:    presc_d = wrap ? '0 : presc_q + 1'b1;
      ST_PAUSED: presc_d = presc_q;
      default:   presc_d = '0;
    endcase
  end

  // Outputs
  always_comb begin
    wrap = (state_q == ST_RUN) && (presc_q == PRESCALE_W'(PRESCALE - 1));
`ifdef SINGLE_STEP_EN
    step_tick = (state_q == ST_PAUSED) && step;
`else
    step_tick = 1'b0;
`endif
    base_tick = wrap || step_tick;
    state     = state_q;
  end

`ifndef SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  // Speed-up saturates at MIN_PERIOD; the counter keeps running.
  assign speed_dec = speed_up && (period[0] > PERIOD_W'(MIN_PERIOD));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                cfg_hit;
    logic                period_we;
    logic [PERIOD_W-1:0] period_new;

    assign cfg_hit = cfg_we && (cfg_ch == ($clog2(NUM_CH))'(i));

    if (i == 0) begin : g_speed
      assign period_we  = cfg_hit || speed_dec;
      assign period_new = cfg_hit ? cfg_period : period[0] - 1'b1;
    end else begin : g_plain
      assign period_we  = cfg_hit;
      assign period_new = cfg_period;
    end

    game_tick_channel #(
      .PERIOD_W   (PERIOD_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .base_tick  (base_tick),
      .period_we  (period_we),
      .period_new (period_new),
      .cnt_clr    (cfg_hit || state_q == ST_IDLE),
      .period     (period[i]),
      .tick       (tick[i])
    );
  end

endmodule
